jpeg_idct_tbuf: RTL and testbench
=================================

# jpeg_idct_tbuf

Parametrised transpose buffer between the row and column passes of the iDCT. The row pass writes mirror-pair coefficients (k, 7-k) of each row, and the column pass reads mirror-pair coefficients (j, 7-j) of each column. It is an N-bank circular store of 8x8 blocks with ready/available flow control, block occupancy count, sticky error flags, and a selectable transposed or row-order read mode.

## Interface
Parameters:
- DW, 16: coefficient width.
- BANKS, 4: number of 8x8 block banks; power of two, 2..8.
- TRANSPOSE, 1: 1 = column-order read; 0 = row-order read.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- init  in  1  synchronous clear of pointers, count and error flags.
- in_valid  in  1  write request.
- in_ready  out  1  write bank available.
- in_addr  in  5  row r = in_addr[4:2], pair k = in_addr[1:0].
- in_a  in  DW  element (r, k).
- in_b  in  DW  element (r, 7-k).
- out_avail  out  1  at least one complete bank is stored.
- out_read  in  1  read request.
- out_addr  in  5  major index c = out_addr[4:2], pair j = out_addr[1:0].
- out_a  out  DW  TRANSPOSE=1: element (j, c); TRANSPOSE=0: element (c, j).
- out_b  out  DW  TRANSPOSE=1: element (7-j, c); TRANSPOSE=0: element (c, 7-j).
- count  out  $clog2(BANKS)+1  number of complete, unreleased banks.
- ovf_err  out  1  sticky: write attempted while in_ready=0.
- udf_err  out  1  sticky: read attempted while out_avail=0.

## Operation
- Pointers: wr_ptr and rd_ptr are each $clog2(BANKS)+1 bits. count = wr_ptr - rd_ptr.
- Flags: in_ready = (count != BANKS). out_avail = (count != 0).
- Write acceptance: a write is accepted when in_valid && in_ready. Accepted writes store both elements into bank wr_ptr[low bits].
- Write commit: accepting in_addr = 31 increments wr_ptr.
- Write order: any order is allowed within a bank. Rewriting an address overwrites it.
- Storage: two simple dual-port RAMs, RAM0 and RAM1, each BANKS*32 x DW.
  - Element (row, col) lives in RAM (row[2] ^ col[2]) at word {bank, row, col[1:0]}.
  - Every write pair and every read pair therefore hits different RAMs. This gives one write and one read per RAM per cycle.
- Reads: a read is performed when out_read && out_avail, using bank rd_ptr[low bits].
- Read release: reading out_addr = 31 increments rd_ptr after the read. The data for that read comes from the released bank.
- Write overflow: in_valid && !in_ready drops the write, sets ovf_err, and leaves pointers unchanged.
- Read underflow: out_read && !out_avail sets udf_err. Pointers are unchanged and out_a/out_b hold their previous values.
- Simultaneous write commit and read release: count is unchanged and both pointers advance.
- init: has priority over all same-cycle writes and reads. It zeroes both pointers, count, ovf_err and udf_err. RAM contents are not cleared.
- Wrap-around: pointers wrap modulo 2*BANKS. Bank index is the pointer modulo BANKS.

## Timing
- Reset values: in_ready=1, out_avail=0, count=0, ovf_err=0, udf_err=0, out_a=0, out_b=0. RAMs are not reset.
- Write latency: a write committed in cycle t is readable from cycle t+1. out_avail and count update at the t+1 edge.
- Read latency: out_a/out_b are registered and valid the cycle after out_read is sampled. They hold while no read is performed.
- Flag timing: in_ready and out_avail are derived from registered pointers only. There is no combinational path from in_valid or out_read to either flag.
- Release while full: a release in the same cycle as count=BANKS does not raise in_ready until the next cycle.
- No read-during-write hazard: the read bank and write bank differ whenever both are active.
- Throughput: 32 cycles per block per side at full rate.

## Test plan
- Transposed readback (TRANSPOSE=1): write one block with element (r,col) = r*8+col, then read addr {c=2, j=1}. Next cycle out_a=10 and out_b=50.
- Row-order readback (TRANSPOSE=0): same block, read addr {c=2, j=1}. Next cycle out_a=17 and out_b=22.
- Full and overflow: fill 4 banks with no reads. count=4 and in_ready=0. A further in_valid sets ovf_err=1 and leaves stored data intact.
- Release/commit overlap: with count=2, release bank and commit a bank in the same cycle. count stays 2 and both pointers advance; continue through a pointer wrap with data checked.
- Underflow: out_read with count=0 sets udf_err=1 and out_a holds its value. Then init clears udf_err and count.
- Reset mid-stream: assert rst after 17 writes. All outputs return to reset values. A fresh block written afterward reads back correctly.

Source files
------------

// File: rtl/jpeg_idct_tbuf.sv
// =============================================================================
// Module  : jpeg_idct_tbuf
// Brief   : Banked 8x8 transpose buffer between the iDCT row and column passes.
//           Writes mirror pairs (r,k)/(r,7-k), reads mirror pairs either
//           column-wise (j,c)/(7-j,c) or row-wise (c,j)/(c,7-j).
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module jpeg_idct_tbuf #(
    parameter int DW        = 16,
    parameter int BANKS     = 4,
    parameter int TRANSPOSE = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       init,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4:0]                 in_addr,
    input  logic [DW-1:0]              in_a,
    input  logic [DW-1:0]              in_b,
    output logic                       out_avail,
    input  logic                       out_read,
    input  logic [4:0]                 out_addr,
    output logic [DW-1:0]              out_a,
    output logic [DW-1:0]              out_b,
    output logic [$clog2(BANKS):0]     count,
    output logic                       ovf_err,
    output logic                       udf_err
);

    localparam int BW    = $clog2(BANKS);
    localparam int PW    = BW + 1;
    localparam int AW    = BW + 5;
    localparam int DEPTH = BANKS * 32;
    localparam logic [PW-1:0] C_FULL = PW'(BANKS);

    // Pointer / flag state
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          ovf_q,    ovf_d;
    logic          udf_q,    udf_d;
    logic [DW-1:0] out_a_q;
    logic [DW-1:0] out_b_q;

    // Two RAMs; an element's RAM is chosen by row[2]^col[2] so each mirror
    // pair always splits across both RAMs.
    logic [DW-1:0] ram0 [DEPTH];
    logic [DW-1:0] ram1 [DEPTH];

    logic [PW-1:0] cnt_w;
    logic          wr_en_w;
    logic          rd_en_w;

    assign cnt_w     = wr_ptr_q - rd_ptr_q;
    assign in_ready  = (cnt_w != C_FULL);
    assign out_avail = (cnt_w != '0);
    assign count     = cnt_w;
    assign ovf_err   = ovf_q;
    assign udf_err   = udf_q;
    assign out_a     = out_a_q;
    assign out_b     = out_b_q;

    // init suppresses any same-cycle transfer
    assign wr_en_w = in_valid && in_ready && !init;
    assign rd_en_w = out_read && out_avail && !init;

    // ---------------------------------------------------------------- write side
    logic [BW-1:0] wbank_w;
    logic [2:0]    wrow_w;
    logic [1:0]    wk_w;
    logic [AW-1:0] waddr_a_w, waddr_b_w;
    logic [AW-1:0] waddr0_w,  waddr1_w;
    logic [DW-1:0] wdata0_w,  wdata1_w;

    assign wbank_w   = wr_ptr_q[BW-1:0];
    assign wrow_w    = in_addr[4:2];
    assign wk_w      = in_addr[1:0];
    // element a sits in column k (col[2]=0), element b in column 7-k (col[2]=1)
    assign waddr_a_w = {wbank_w, wrow_w, wk_w};
    assign waddr_b_w = {wbank_w, wrow_w, ~wk_w};
    assign waddr0_w  = wrow_w[2] ? waddr_b_w : waddr_a_w;
    assign waddr1_w  = wrow_w[2] ? waddr_a_w : waddr_b_w;
    assign wdata0_w  = wrow_w[2] ? in_b : in_a;
    assign wdata1_w  = wrow_w[2] ? in_a : in_b;

    // RAM write ports (contents are never reset)
    always_ff @(posedge clk) begin
        if (wr_en_w) begin
            ram0[waddr0_w] <= wdata0_w;
            ram1[waddr1_w] <= wdata1_w;
        end
    end

    // ----------------------------------------------------------------- read side
    logic [BW-1:0] rbank_w;
    logic [2:0]    rc_w;
    logic [1:0]    rj_w;
    logic [AW-1:0] raddr_a_w, raddr_b_w;
    logic [AW-1:0] raddr0_w,  raddr1_w;

    assign rbank_w = rd_ptr_q[BW-1:0];
    assign rc_w    = out_addr[4:2];
    assign rj_w    = out_addr[1:0];

    if (TRANSPOSE != 0) begin : g_col_order
        // a = (j, c), b = (7-j, c)
        assign raddr_a_w = {rbank_w, 1'b0, rj_w,  rc_w[1:0]};
        assign raddr_b_w = {rbank_w, 1'b1, ~rj_w, rc_w[1:0]};
    end else begin : g_row_order
        // a = (c, j), b = (c, 7-j)
        assign raddr_a_w = {rbank_w, rc_w, rj_w};
        assign raddr_b_w = {rbank_w, rc_w, ~rj_w};
    end

    // In both modes element a lives in RAM c[2] and element b in the other one
    assign raddr0_w = rc_w[2] ? raddr_b_w : raddr_a_w;
    assign raddr1_w = rc_w[2] ? raddr_a_w : raddr_b_w;

    // Registered read data; holds whenever no read is performed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_a_q <= '0;
            out_b_q <= '0;
        end else if (rd_en_w) begin
            out_a_q <= rc_w[2] ? ram1[raddr1_w] : ram0[raddr0_w];
            out_b_q <= rc_w[2] ? ram0[raddr0_w] : ram1[raddr1_w];
        end
    end

    // ------------------------------------------------------------ pointer control
    // Next-state for pointers and sticky error flags
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;
        if (init) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end else begin
            if (wr_en_w && (in_addr == 5'd31))
                wr_ptr_d = wr_ptr_q + 1'b1;
            if (rd_en_w && (out_addr == 5'd31))
                rd_ptr_d = rd_ptr_q + 1'b1;
            if (in_valid && !in_ready)
                ovf_d = 1'b1;
            if (out_read && !out_avail)
                udf_d = 1'b1;
        end
    end

    // Pointer and error-flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_jpeg_idct_tbuf.sv
// =============================================================================
// Module  : tb_jpeg_idct_tbuf
// Brief   : Directed self-checking bench; one column-order and one row-order
//           instance share all inputs.
// Revision: 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_jpeg_idct_tbuf;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          init = 1'b0;
    logic          in_valid = 1'b0;
    logic [4:0]    in_addr = '0;
    logic [DW-1:0] in_a = '0;
    logic [DW-1:0] in_b = '0;
    logic          out_read = 1'b0;
    logic [4:0]    out_addr = '0;

    logic          t_in_ready, t_out_avail, t_ovf, t_udf;
    logic [DW-1:0] t_out_a, t_out_b;
    logic [2:0]    t_count;
    logic          r_in_ready, r_out_avail, r_ovf, r_udf;
    logic [DW-1:0] r_out_a, r_out_b;
    logic [2:0]    r_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    jpeg_idct_tbuf #(.DW(DW), .BANKS(4), .TRANSPOSE(1)) u_col (
        .clk(clk), .rst(rst), .init(init),
        .in_valid(in_valid), .in_ready(t_in_ready), .in_addr(in_addr),
        .in_a(in_a), .in_b(in_b),
        .out_avail(t_out_avail), .out_read(out_read), .out_addr(out_addr),
        .out_a(t_out_a), .out_b(t_out_b), .count(t_count),
        .ovf_err(t_ovf), .udf_err(t_udf)
    );

    jpeg_idct_tbuf #(.DW(DW), .BANKS(4), .TRANSPOSE(0)) u_row (
        .clk(clk), .rst(rst), .init(init),
        .in_valid(in_valid), .in_ready(r_in_ready), .in_addr(in_addr),
        .in_a(in_a), .in_b(in_b),
        .out_avail(r_out_avail), .out_read(out_read), .out_addr(out_addr),
        .out_a(r_out_a), .out_b(r_out_b), .count(r_count),
        .ovf_err(r_ovf), .udf_err(r_udf)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Expected element value of a block filled with base + row*8 + col
    function automatic int exp_val(input int base, input int transpose,
                                   input int addr, input int is_b);
        int c, j, row, col;
        c = addr / 4;
        j = addr % 4;
        if (transpose != 0) begin
            row = (is_b != 0) ? 7 - j : j;
            col = c;
        end else begin
            row = c;
            col = (is_b != 0) ? 7 - j : j;
        end
        return base + row * 8 + col;
    endfunction

    task automatic chk_out(input string tag, input int base, input int addr);
        chk({tag, "_col_a"}, int'(t_out_a), exp_val(base, 1, addr, 0));
        chk({tag, "_col_b"}, int'(t_out_b), exp_val(base, 1, addr, 1));
        chk({tag, "_row_a"}, int'(r_out_a), exp_val(base, 0, addr, 0));
        chk({tag, "_row_b"}, int'(r_out_b), exp_val(base, 0, addr, 1));
    endtask

    task automatic chk_count(input string tag, input int exp);
        chk({tag, "_col"}, int'(t_count), exp);
        chk({tag, "_row"}, int'(r_count), exp);
    endtask

    // Drive one write beat for pair address a of a block with the given base
    task automatic drive_wr(input int base, input int a);
        in_valid = 1'b1;
        in_addr  = 5'(a);
        in_a     = DW'(base + (a / 4) * 8 + (a % 4));
        in_b     = DW'(base + (a / 4) * 8 + (7 - (a % 4)));
    endtask

    task automatic write_beats(input int base, input int n);
        for (int a = 0; a < n; a++) begin
            @(negedge clk);
            drive_wr(base, a);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full-rate read of one bank, checking addresses 9 and 31
    task automatic read_block(input string tag, input int base);
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            if (a == 10) chk_out({tag, "_a9"}, base, 9);
            out_read = 1'b1;
            out_addr = 5'(a);
        end
        @(negedge clk);
        out_read = 1'b0;
        chk_out({tag, "_a31"}, base, 31);
    endtask

    initial begin
        // ---------------- reset state
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", int'(t_in_ready), 1);
        chk("rst_out_avail", int'(t_out_avail), 0);
        chk_count("rst_count", 0);
        chk("rst_ovf", int'(t_ovf), 0);
        chk("rst_udf", int'(r_udf), 0);
        chk("rst_out_a", int'(t_out_a), 0);
        chk("rst_out_b", int'(r_out_b), 0);

        // ---------------- single block, both read orders
        write_beats(0, 32);
        chk_count("blk0_count", 1);
        chk("blk0_avail", int'(t_out_avail), 1);
        @(negedge clk);
        out_read = 1'b1;
        out_addr = 5'd9;
        @(negedge clk);
        out_read = 1'b0;
        chk("probe_col_a", int'(t_out_a), 10);
        chk("probe_col_b", int'(t_out_b), 50);
        chk("probe_row_a", int'(r_out_a), 17);
        chk("probe_row_b", int'(r_out_b), 22);
        chk_count("probe_no_release", 1);

        // ---------------- fill to full, then overflow
        write_beats(100, 32);
        write_beats(200, 32);
        write_beats(300, 32);
        chk_count("full_count", 4);
        chk("full_in_ready", int'(t_in_ready), 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_addr  = 5'd0;
        in_a     = 16'd9999;
        in_b     = 16'd9999;
        @(negedge clk);
        in_valid = 1'b0;
        chk("ovf_set", int'(t_ovf), 1);
        chk("ovf_set_row", int'(r_ovf), 1);
        chk_count("ovf_count", 4);

        // read first bank back (overflow write targeted this bank index)
        @(negedge clk);
        out_read = 1'b1;
        out_addr = 5'd0;
        @(negedge clk);
        out_read = 1'b0;
        chk_out("ovf_intact", 0, 0);
        read_block("bank0", 0);
        chk_count("release_from_full", 3);
        chk("in_ready_after_release", int'(t_in_ready), 1);
        read_block("bank1", 100);
        read_block("bank2", 200);
        chk_count("after_3_reads", 1);
        write_beats(400, 32);
        chk_count("before_overlap", 2);

        // ---------------- simultaneous commit and release
        for (int a = 0; a < 32; a++) begin
            @(negedge clk);
            if (a == 10) chk_out("overlap_a9", 300, 9);
            drive_wr(500, a);
            out_read = 1'b1;
            out_addr = 5'(a);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_read = 1'b0;
        chk_out("overlap_a31", 300, 31);
        chk_count("overlap_count", 2);

        // ---------------- continue through a pointer wrap
        read_block("bank4", 400);
        read_block("bank5", 500);
        chk_count("drained", 0);
        write_beats(600, 32);
        write_beats(700, 32);
        chk_count("wrap_count", 2);
        read_block("wrap6", 600);
        read_block("wrap7", 700);
        chk_count("wrap_drained", 0);

        // ---------------- underflow and init
        @(negedge clk);
        out_read = 1'b1;
        out_addr = 5'd9;
        @(negedge clk);
        out_read = 1'b0;
        chk("udf_set", int'(t_udf), 1);
        chk("udf_set_row", int'(r_udf), 1);
        chk_out("udf_hold", 700, 31);
        write_beats(900, 32);
        chk_count("pre_init", 1);
        chk("ovf_sticky", int'(t_ovf), 1);
        @(negedge clk);
        init = 1'b1;
        @(negedge clk);
        init = 1'b0;
        chk("init_udf", int'(t_udf), 0);
        chk("init_ovf", int'(t_ovf), 0);
        chk_count("init_count", 0);
        chk("init_avail", int'(t_out_avail), 0);

        // ---------------- reset mid-stream
        for (int a = 0; a < 17; a++) begin
            @(negedge clk);
            drive_wr(1000, a);
            out_read = (a == 5);
            out_addr = 5'd0;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_read = 1'b0;
        rst = 1'b0;
        #1;
        chk("mid_rst_in_ready", int'(t_in_ready), 1);
        chk("mid_rst_avail", int'(r_out_avail), 0);
        chk_count("mid_rst_count", 0);
        chk("mid_rst_out_a", int'(t_out_a), 0);
        chk("mid_rst_out_b", int'(r_out_b), 0);
        chk("mid_rst_ovf", int'(t_ovf), 0);
        chk("mid_rst_udf", int'(r_udf), 0);
        @(negedge clk);
        rst = 1'b1;
        write_beats(1100, 32);
        chk_count("fresh_count", 1);
        read_block("fresh", 1100);
        chk_count("fresh_drained", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
